// File: rtl/tagged_word_receiver_pkg.sv
// Shared types and bus layout for the tagged-word strobe receiver.
package tagged_word_pkg;

  localparam int unsigned TAG_BIT   = 8;
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned BUS_W     = 9;

  typedef logic [PAYLOAD_W-1:0] payload_t;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_state_t;

endpackage

// File: rtl/tagged_word_receiver_if.sv
// Valid/ready drain stream from the receiver FIFO toward the consumer.
interface tagged_word_receiver_if;
  import tagged_word_pkg::*;

  payload_t out_data;
  logic     out_valid;
  logic     out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/tagged_word_receiver_fifo.sv
// DEPTH x payload FIFO with a registered head word and occupancy-driven fill state.
module tw_fifo
  import tagged_word_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  payload_t wdata,
  input  logic     pop,
  output payload_t rdata,
  output logic     empty,
  output logic     full,
  output logic     accept
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  payload_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]     count, count_next;
  fill_state_t       state, state_next;
  payload_t          head_next;
  logic              head_load;
  logic              do_pop, do_push;

  assign empty  = (state == FILL_EMPTY);
  assign full   = (state == FILL_FULL);
  assign accept = do_push;

  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    rd_next    = rd_ptr + 1'b1;
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    // Head register: next entry after a pop, or the incoming word when it becomes the head.
    head_load = 1'b0;
    head_next = rdata;
    if (do_pop) begin
      if (count != CNT_ONE) begin
        head_load = 1'b1;
        head_next = mem[rd_next];
      end else if (do_push) begin
        head_load = 1'b1;
        head_next = wdata;
      end
    end else if (do_push && empty) begin
      head_load = 1'b1;
      head_next = wdata;
    end

    state_next = FILL_PARTIAL;
    if (count_next == '0) begin
      state_next = FILL_EMPTY;
    end else if (count_next == CNT_FULL) begin
      state_next = FILL_FULL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FILL_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      if (head_load) rdata <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tagged_word_receiver.sv
// Receiving end of the tagged-word strobe bus: tag detect, FIFO buffering, overflow and word count.
module tagged_word_receiver
  import tagged_word_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUS_W-1:0]        data,
  tagged_word_receiver_if.master  stream,
  output logic                    full,
  output logic                    overflow,
  input  logic                    clear_ovf,
  output logic [CNT_W-1:0]        word_count
);

  logic tag_q;
  logic push_req;
  logic accept;
  logic empty;
  logic pop;

  assign push_req = (EDGE_MODE != 0) ? (data[TAG_BIT] & ~tag_q) : data[TAG_BIT];
  assign pop      = ~empty & stream.out_ready;

  assign stream.out_valid = ~empty;

  tw_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_req),
    .wdata  (payload_t'(data[PAYLOAD_W-1:0])),
    .pop    (pop),
    .rdata  (stream.out_data),
    .empty  (empty),
    .full   (full),
    .accept (accept)
  );

  // A dropped word takes priority over a same-cycle clear so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      tag_q <= data[TAG_BIT];
      if (push_req && !accept) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
      if (accept) word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_tagged_word_receiver.sv
// Directed bench: an edge-mode and a level-mode receiver driven with hand-computed vectors.
module tb_tagged_word_receiver;

  logic       clk;
  logic       reset;
  logic       clear_ovf;
  logic [8:0] data_e, data_l;
  logic       full_e, full_l, ovf_e, ovf_l;
  logic [7:0] cnt_e, cnt_l;
  int         errors;
  int         checks;

  tagged_word_receiver_if if_e ();
  tagged_word_receiver_if if_l ();

  tagged_word_receiver #(
    .DEPTH     (4),
    .EDGE_MODE (1),
    .CNT_W     (8)
  ) dut_e (
    .clk        (clk),
    .reset      (reset),
    .data       (data_e),
    .stream     (if_e),
    .full       (full_e),
    .overflow   (ovf_e),
    .clear_ovf  (clear_ovf),
    .word_count (cnt_e)
  );

  tagged_word_receiver #(
    .DEPTH     (4),
    .EDGE_MODE (0),
    .CNT_W     (8)
  ) dut_l (
    .clk        (clk),
    .reset      (reset),
    .data       (data_l),
    .stream     (if_l),
    .full       (full_l),
    .overflow   (ovf_l),
    .clear_ovf  (clear_ovf),
    .word_count (cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] expd [4];
    logic [7:0] b;
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    clear_ovf      = 1'b0;
    data_e         = 9'h000;
    data_l         = 9'h000;
    if_e.out_ready = 1'b0;
    if_l.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_valid", 32'(if_e.out_valid), 0);
    chk("rst_full", 32'(full_e), 0);
    chk("rst_ovf", 32'(ovf_e), 0);
    chk("rst_count", 32'(cnt_e), 0);
    chk("rst_data", 32'(if_e.out_data), 0);

    // Edge mode: steady tagged word counts once
    reset  = 1'b0;
    data_e = 9'h1A5;
    tick();
    chk("edge_valid_1cyc", 32'(if_e.out_valid), 1);
    chk("edge_data_1cyc", 32'(if_e.out_data), 32'hA5);
    chk("edge_count_1cyc", 32'(cnt_e), 1);
    tick();
    tick();
    chk("edge_count_steady", 32'(cnt_e), 1);
    data_e         = 9'h0A5;
    if_e.out_ready = 1'b1;
    tick();
    chk("edge_one_word", 32'(if_e.out_valid), 0);
    data_e         = 9'h13C;
    if_e.out_ready = 1'b0;
    tick();
    chk("edge_rearm_count", 32'(cnt_e), 2);
    chk("edge_rearm_data", 32'(if_e.out_data), 32'h3C);
    data_e = 9'h000;

    // Level mode: fill, overflow, drain in order
    data_l = 9'h101;
    tick();
    chk("lvl_first_data", 32'(if_l.out_data), 32'h01);
    data_l = 9'h102;
    tick();
    data_l = 9'h103;
    tick();
    chk("lvl_not_full", 32'(full_l), 0);
    data_l = 9'h104;
    tick();
    chk("lvl_full", 32'(full_l), 1);
    chk("lvl_count4", 32'(cnt_l), 4);
    data_l = 9'h105;
    tick();
    chk("lvl_ovf", 32'(ovf_l), 1);
    chk("lvl_drop_count", 32'(cnt_l), 4);
    chk("lvl_head_kept", 32'(if_l.out_data), 32'h01);
    data_l         = 9'h000;
    if_l.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("lvl_drain_valid", 32'(if_l.out_valid), 1);
      chk("lvl_drain_data", 32'(if_l.out_data), 32'(i));
      tick();
    end
    chk("lvl_drained", 32'(if_l.out_valid), 0);
    if_l.out_ready = 1'b0;

    // Overflow clear vs. same-cycle drop
    clear_ovf = 1'b1;
    tick();
    chk("clr_alone_1", 32'(ovf_l), 0);
    clear_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_l = 9'h111 + 9'(i);
      tick();
    end
    chk("refill_full", 32'(full_l), 1);
    chk("refill_count", 32'(cnt_l), 8);
    chk("refill_head", 32'(if_l.out_data), 32'h11);
    data_l    = 9'h115;
    clear_ovf = 1'b1;
    tick();
    chk("clr_vs_drop", 32'(ovf_l), 1);
    chk("clr_vs_drop_cnt", 32'(cnt_l), 8);
    data_l = 9'h000;
    tick();
    chk("clr_alone_2", 32'(ovf_l), 0);
    clear_ovf = 1'b0;

    // Full with simultaneous push and pop
    data_l         = 9'h1FF;
    if_l.out_ready = 1'b1;
    tick();
    chk("fullpp_ovf", 32'(ovf_l), 0);
    chk("fullpp_full", 32'(full_l), 1);
    chk("fullpp_count", 32'(cnt_l), 9);
    data_l  = 9'h000;
    expd[0] = 8'h12;
    expd[1] = 8'h13;
    expd[2] = 8'h14;
    expd[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_drain", 32'(if_l.out_data), 32'(expd[i]));
      tick();
    end
    chk("fullpp_empty", 32'(if_l.out_valid), 0);

    // Push while empty with ready high: no bypass
    data_l = 9'h133;
    tick();
    chk("empty_pp_valid", 32'(if_l.out_valid), 1);
    chk("empty_pp_data", 32'(if_l.out_data), 32'h33);
    chk("empty_pp_count", 32'(cnt_l), 10);
    data_l = 9'h000;
    tick();
    chk("empty_pp_popped", 32'(if_l.out_valid), 0);
    if_l.out_ready = 1'b0;

    // Asynchronous reset with three words buffered
    for (int i = 0; i < 3; i++) begin
      data_l = 9'h121 + 9'(i);
      tick();
    end
    data_l = 9'h000;
    chk("pre_rst_count", 32'(cnt_l), 13);
    chk("pre_rst_head", 32'(if_l.out_data), 32'h21);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(if_l.out_valid), 0);
    chk("arst_full", 32'(full_l), 0);
    chk("arst_count", 32'(cnt_l), 0);
    chk("arst_data", 32'(if_l.out_data), 0);
    chk("arst_count_e", 32'(cnt_e), 0);
    chk("arst_valid_e", 32'(if_e.out_valid), 0);
    #2;
    reset = 1'b0;
    tick();
    chk("arst_lost", 32'(if_l.out_valid), 0);

    // 256 words streamed through while draining: counter wraps, nothing lost
    if_l.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b      = 8'(i);
      data_l = {1'b1, b};
      tick();
      chk("stream_data", 32'(if_l.out_data), 32'(b));
    end
    chk("wrap_count", 32'(cnt_l), 0);
    chk("wrap_ovf", 32'(ovf_l), 0);
    data_l = 9'h000;
    tick();
    chk("wrap_drained", 32'(if_l.out_valid), 0);
    if_l.out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
